// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request sequencer in front of the 256x32 data memory.
// Accepts one read/write request at a time, drives the memory pins, and
// returns read data on a valid/ready response channel. Partial writes are
// split into a read of the old word followed by a write of the merged word.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a new request, memory pins parked
//   RD     | memory read strobe, dout captured into rsp_rdata
//   RESP   | read data presented, waiting for rsp_ready
//   WR     | full-word write strobe of wdata_q
//   RMW_RD | read old word, merge_q built from it and the enabled bytes
//   RMW_WR | write merge_q back to the same address
module mem_req_ctrl #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    inout  wire                dvdd,
    inout  wire                dgnd,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [AW-1:0]      req_addr,
    input  logic [DW-1:0]      req_wdata,
    input  logic [DW/8-1:0]    req_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_en,
    output logic               mem_rw,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout,
    output logic               mem_rstz
);

    localparam int BW = DW / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RESP   = 3'd2,
        WR     = 3'd3,
        RMW_RD = 3'd4,
        RMW_WR = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   be_q;
    logic [DW-1:0]   merge_q;
    logic [DW-1:0]   merge_d;
    logic [DW-1:0]   rdata_q;
    logic            accept;

    // Supply pins only pass through this block; tie them off logically.
    logic unused_supply;
    assign unused_supply = dvdd ^ dgnd;

    assign req_ready = (state == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign rsp_rdata = rdata_q;
    assign mem_rstz  = ~rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request capture, read-data capture and merged-word capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (state == RD)     rdata_q <= mem_dout;
            if (state == RMW_RD) merge_q <= merge_d;
        end
    end

    // Byte-lane merge of new write data over the word currently in memory.
    always_comb begin
        merge_d = mem_dout;
        for (int i = 0; i < BW; i++) begin
            if (be_q[i]) merge_d[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Next-state logic; a write with no enabled bytes is absorbed in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_we)          state_nxt = RD;
                    else if (&req_be)     state_nxt = WR;
                    else if (|req_be)     state_nxt = RMW_RD;
                    else                  state_nxt = IDLE;
                end
            end
            RD:      state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory pin and response outputs; everything is parked while rst is high
    // so a write in flight cannot strobe during reset.
    always_comb begin
        mem_en    = 1'b0;
        mem_rw    = 1'b1;
        mem_addr  = '0;
        mem_din   = '0;
        rsp_valid = 1'b0;
        if (!rst) begin
            case (state)
                RD, RMW_RD: begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                end
                WR: begin
                    mem_en   = 1'b1;
                    mem_rw   = 1'b0;
                    mem_addr = addr_q;
                    mem_din  = wdata_q;
                end
                RMW_WR: begin
                    mem_en   = 1'b1;
                    mem_rw   = 1'b0;
                    mem_addr = addr_q;
                    mem_din  = merge_q;
                end
                RESP:    rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed scenarios plus randomized traffic for mem_req_ctrl,
// with a word-level memory model on the pins and a request-level shadow array.
`timescale 1ns/1ps
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire         dvdd;
    wire         dgnd;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        mem_en;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_rstz;

    assign dvdd = 1'b1;
    assign dgnd = 1'b0;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    bit mon_on = 1'b0;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];

    mem_req_ctrl #(.AW(8), .DW(32)) dut (
        .clk(clk), .rst(rst), .dvdd(dvdd), .dgnd(dgnd),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_rstz(mem_rstz)
    );

    always #5 clk = ~clk;

    // Memory model: clears while rstz is low, writes on en & ~rw, combinational read.
    always @(posedge clk) begin
        if (!mem_rstz) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
        end else if (mem_en && !mem_rw) begin
            mem_arr[mem_addr] <= mem_din;
        end
        if (mem_en && !mem_rw) wr_pulses++;
    end
    assign mem_dout = mem_arr[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Whenever the memory is not strobed its pins must be parked.
    always @(negedge clk) begin
        if (mon_on && !mem_en)
            chk("idle_pins", {23'd0, mem_rw, mem_addr, mem_din}, {23'd0, 1'b1, 8'h00, 32'h0});
    end

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        if (be[0]) m = m | 32'h0000_00FF;
        if (be[1]) m = m | 32'h0000_FF00;
        if (be[2]) m = m | 32'h00FF_0000;
        if (be[3]) m = m | 32'hFF00_0000;
        return m;
    endfunction

    // One complete transaction; checks pins cycle by cycle and updates the shadow.
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int rsp_delay, output logic [31:0] rdata);
        int wp0;
        logic [31:0] exp_word;
        logic [31:0] held;
        rdata = '0;
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        rsp_ready = 1'($urandom % 2);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        wp0 = wr_pulses;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = 8'($urandom); req_be = 4'($urandom);
        @(negedge clk);
        if (!we) begin
            rsp_ready = 1'b0;
            chk("rd_pins", {54'd0, mem_en, mem_rw, mem_addr}, {54'd0, 1'b1, 1'b1, addr});
            chk("rd_not_ready", {63'd0, req_ready}, 64'd0);
            chk("rd_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
            exp_word = ref_mem[addr];
            @(negedge clk);
            chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_word});
            held = rsp_rdata;
            for (int k = 0; k < rsp_delay; k++) begin
                req_valid = 1'($urandom % 2); req_we = 1'b1; req_be = 4'hF;
                @(negedge clk);
                chk("rsp_hold_valid", {63'd0, rsp_valid}, 64'd1);
                chk("rsp_hold_data", {32'd0, rsp_rdata}, {32'd0, held});
                chk("rsp_hold_busy", {63'd0, req_ready}, 64'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            rdata = rsp_rdata;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("rsp_done", {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
            chk("rd_no_write", 64'(wr_pulses - wp0), 64'd0);
        end else if (be == 4'hF) begin
            chk("wr_pins", {22'd0, mem_en, mem_rw, mem_addr, mem_din}, {22'd0, 1'b1, 1'b0, addr, wdata});
            chk("wr_busy", {63'd0, req_ready}, 64'd0);
            ref_mem[addr] = wdata;
            @(negedge clk);
            chk("wr_done", {62'd0, mem_en, req_ready}, {62'd0, 1'b0, 1'b1});
            chk("wr_one_pulse", 64'(wr_pulses - wp0), 64'd1);
        end else if (be == 4'h0) begin
            chk("nop_pins", {62'd0, mem_en, req_ready}, {62'd0, 1'b0, 1'b1});
            chk("nop_no_write", 64'(wr_pulses - wp0), 64'd0);
        end else begin
            chk("rmw_rd_pins", {54'd0, mem_en, mem_rw, mem_addr}, {54'd0, 1'b1, 1'b1, addr});
            chk("rmw_busy", {63'd0, req_ready}, 64'd0);
            exp_word = (ref_mem[addr] & ~byte_mask(be)) | (wdata & byte_mask(be));
            @(negedge clk);
            chk("rmw_wr_pins", {22'd0, mem_en, mem_rw, mem_addr, mem_din}, {22'd0, 1'b1, 1'b0, addr, exp_word});
            chk("rmw_busy2", {63'd0, req_ready}, 64'd0);
            ref_mem[addr] = exp_word;
            @(negedge clk);
            chk("rmw_done", {62'd0, mem_en, req_ready}, {62'd0, 1'b0, 1'b1});
            chk("rmw_one_pulse", 64'(wr_pulses - wp0), 64'd1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int wp0;
        logic [7:0] a;
        logic [3:0] b;
        int sel;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready_low", {62'd0, req_ready, mem_rstz}, {62'd0, 1'b0, 1'b0});
        rst = 1'b0;
        #1;
        chk("reset_outputs", {20'd0, req_ready, rsp_valid, mem_en, mem_rw, mem_addr, mem_din},
            {20'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0});
        chk("reset_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("reset_rstz", {63'd0, mem_rstz}, 64'd1);
        mon_on = 1'b1;

        // Full write then read back.
        do_req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, rd);
        chk("t1_data", {32'd0, rd}, {32'd0, 32'hDEADBEEF});

        // Partial write of the low half-word.
        do_req(1'b1, 8'h10, 32'h0000_1234, 4'b0011, 0, rd);
        do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, rd);
        chk("t2_data", {32'd0, rd}, {32'd0, 32'hDEAD1234});

        // Back-pressured response.
        do_req(1'b0, 8'h10, 32'h0, 4'h0, 5, rd);
        chk("t3_data", {32'd0, rd}, {32'd0, 32'hDEAD1234});

        // Write with no byte enables leaves memory untouched.
        do_req(1'b1, 8'h20, 32'h55AA_33CC, 4'hF, 0, rd);
        do_req(1'b1, 8'h20, 32'hFFFF_FFFF, 4'h0, 0, rd);
        do_req(1'b0, 8'h20, 32'h0, 4'h0, 1, rd);
        chk("t4_data", {32'd0, rd}, {32'd0, 32'h55AA_33CC});

        // Top and bottom of the address range.
        do_req(1'b1, 8'hFF, 32'hA5A5A5A5, 4'hF, 0, rd);
        do_req(1'b0, 8'hFF, 32'h0, 4'h0, 0, rd);
        chk("t6_top", {32'd0, rd}, {32'd0, 32'hA5A5A5A5});
        do_req(1'b0, 8'h00, 32'h0, 4'h0, 0, rd);
        chk("t6_bottom", {32'd0, rd}, 64'd0);

        // Reset while the merged word is about to be written.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_wdata = 32'h1111_2222; req_be = 4'b0101;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t5_in_rmw_rd", {62'd0, mem_en, mem_rw}, {62'd0, 1'b1, 1'b1});
        @(negedge clk);
        chk("t5_in_rmw_wr", {62'd0, mem_en, mem_rw}, {62'd0, 1'b1, 1'b0});
        wp0 = wr_pulses;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_outputs", {19'd0, mem_rstz, req_ready, rsp_valid, mem_en, mem_rw, mem_addr, mem_din},
            {19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0});
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        #1;
        chk("t5_no_write", 64'(wr_pulses - wp0), 64'd0);
        chk("t5_after_rst", {29'd0, req_ready, rsp_valid, mem_en, rsp_rdata},
            {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
        do_req(1'b0, 8'h30, 32'h0, 4'h0, 0, rd);
        chk("t5_cleared_30", {32'd0, rd}, 64'd0);
        do_req(1'b0, 8'hFF, 32'h0, 4'h0, 0, rd);
        chk("t5_cleared_ff", {32'd0, rd}, 64'd0);

        // Randomized traffic on a small address pool plus the range ends.
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom % 10);
            a = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom_range(1, 6));
            sel = int'($urandom % 4);
            b = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
            do_req(1'($urandom % 2), a, $urandom, b, int'($urandom_range(0, 3)), rd);
        end

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
